// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for an RV32I-subset core sharing one ALU, register file
// and immediate decoder. Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and
// drives every datapath enable/select. Memory req/ack handshakes are guarded by a
// watchdog that traps on a stuck bus.
//
// Ports:
//   i_clk, i_rst            clock (rising edge), async active-high reset
//   i_instr                 instruction register contents (stable DECODE..FETCH)
//   i_imem_ack, i_dmem_ack  instruction / data memory acknowledge
//   i_br_taken              branch comparator result, used in EXEC
//   o_imem_req, o_ir_we     instruction fetch request, IR load strobe
//   o_dmem_req, o_dmem_we   data memory request / write
//   o_alu_src, o_signext    ALU operand B select, immediate sign-extend control
//   o_rf_we, o_wb_sel       register-file write strobe and writeback source
//   o_pc_we, o_pc_sel       PC write strobe and next-PC source
//   o_instret, o_trap       retire pulse, sticky trap flag
//   o_state                 current state for debug
module multicycle_ctrl #(
  parameter bit          ZEXT_LOGIC_IMM = 1'b0,
  parameter int unsigned MEM_TIMEOUT    = 255,
  parameter int unsigned TMO_W          = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr,
  input  logic        i_imem_ack,
  input  logic        i_dmem_ack,
  input  logic        i_br_taken,
  output logic        o_imem_req,
  output logic        o_ir_we,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic        o_alu_src,
  output logic        o_signext,
  output logic        o_rf_we,
  output logic [1:0]  o_wb_sel,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_sel,
  output logic        o_instret,
  output logic        o_trap,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsLoad, ClsStore, ClsJal, ClsJalr, ClsBranch, ClsLui, ClsOpImm, ClsOp
  } cls_e;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  // Count value on the last permitted wait cycle.
  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(MEM_TIMEOUT - 1);

  state_e           state_q;
  cls_e             cls_q;
  logic [TMO_W-1:0] tmo_q;
  logic             imem_req_q, dmem_req_q, dmem_we_q;
  logic             alu_src_q, signext_q, rf_we_q, pc_we_q, trap_q;
  logic [1:0]       wb_sel_q, pc_sel_q;

  logic       dec_legal, dec_alu_src, dec_signext;
  cls_e       dec_cls;
  logic [1:0] dec_wb_sel, dec_pc_sel;
  logic [2:0] funct3;
  logic       tmo_hit;
  logic       sw_done;
  logic       unused_instr;

  assign funct3       = i_instr[14:12];
  assign unused_instr = ^{i_instr[31:15], i_instr[11:7]};
  assign tmo_hit      = (MEM_TIMEOUT != 0) && (tmo_q == TmoLast);

  always_comb begin
    dec_legal  = 1'b1;
    dec_cls    = ClsOp;
    dec_wb_sel = 2'b00;
    dec_pc_sel = 2'b00;
    case (i_instr[6:0])
      OpcLoad:   begin dec_cls = ClsLoad;  dec_wb_sel = 2'b01; end
      OpcStore:  dec_cls = ClsStore;
      OpcJal:    begin dec_cls = ClsJal;   dec_wb_sel = 2'b10; dec_pc_sel = 2'b01; end
      OpcJalr:   begin dec_cls = ClsJalr;  dec_wb_sel = 2'b10; dec_pc_sel = 2'b10; end
      OpcBranch: dec_cls = ClsBranch;
      OpcLui:    begin dec_cls = ClsLui;   dec_wb_sel = 2'b11; end
      OpcOpImm:  dec_cls = ClsOpImm;
      OpcOp:     dec_cls = ClsOp;
      default:   dec_legal = 1'b0;
    endcase
    dec_alu_src = dec_legal && (dec_cls != ClsOp) && (dec_cls != ClsBranch);
    // XORI/ORI/ANDI optionally take a zero-extended immediate.
    dec_signext = !(ZEXT_LOGIC_IMM && dec_legal && (dec_cls == ClsOpImm) &&
                    ((funct3 == 3'b100) || (funct3[2:1] == 2'b11)));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StFetch;
      cls_q      <= ClsOp;
      tmo_q      <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      alu_src_q  <= 1'b0;
      signext_q  <= 1'b1;
      rf_we_q    <= 1'b0;
      pc_we_q    <= 1'b0;
      trap_q     <= 1'b0;
      wb_sel_q   <= 2'b00;
      pc_sel_q   <= 2'b00;
    end else begin
      rf_we_q <= 1'b0;
      pc_we_q <= 1'b0;
      case (state_q)
        StFetch: begin
          if (!imem_req_q) begin
            // Only reached right after reset: start the first fetch request.
            imem_req_q <= 1'b1;
          end else if (i_imem_ack) begin
            imem_req_q <= 1'b0;
            tmo_q      <= '0;
            state_q    <= StDecode;
          end else if (tmo_hit) begin
            imem_req_q <= 1'b0;
            tmo_q      <= '0;
            trap_q     <= 1'b1;
            state_q    <= StTrap;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        StDecode: begin
          cls_q     <= dec_cls;
          alu_src_q <= dec_alu_src;
          signext_q <= dec_signext;
          wb_sel_q  <= dec_wb_sel;
          pc_sel_q  <= dec_pc_sel;
          if (!dec_legal) begin
            trap_q  <= 1'b1;
            state_q <= StTrap;
          end else begin
            // Branches retire in EXEC, so their PC strobe is armed here.
            pc_we_q <= (dec_cls == ClsBranch);
            state_q <= StExec;
          end
        end
        StExec: begin
          if (cls_q == ClsBranch) begin
            imem_req_q <= 1'b1;
            state_q    <= StFetch;
          end else if ((cls_q == ClsLoad) || (cls_q == ClsStore)) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= (cls_q == ClsStore);
            state_q    <= StMem;
          end else begin
            rf_we_q <= 1'b1;
            pc_we_q <= 1'b1;
            state_q <= StWb;
          end
        end
        StMem: begin
          if (i_dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            tmo_q      <= '0;
            if (cls_q == ClsStore) begin
              imem_req_q <= 1'b1;
              state_q    <= StFetch;
            end else begin
              rf_we_q <= 1'b1;
              pc_we_q <= 1'b1;
              state_q <= StWb;
            end
          end else if (tmo_hit) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            tmo_q      <= '0;
            trap_q     <= 1'b1;
            state_q    <= StTrap;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        StWb: begin
          imem_req_q <= 1'b1;
          state_q    <= StFetch;
        end
        StTrap: state_q <= StTrap;
        default: begin
          trap_q  <= 1'b1;
          state_q <= StTrap;
        end
      endcase
    end
  end

  // Handshake-qualified strobes must coincide with the ack cycle itself.
  assign sw_done    = dmem_req_q & dmem_we_q & i_dmem_ack;
  assign o_ir_we    = imem_req_q & i_imem_ack;
  assign o_pc_we    = pc_we_q | sw_done;
  assign o_instret  = pc_we_q | sw_done;
  assign o_pc_sel   = ((state_q == StExec) && (cls_q == ClsBranch)) ? {1'b0, i_br_taken}
                                                                  : pc_sel_q;
  assign o_imem_req = imem_req_q;
  assign o_dmem_req = dmem_req_q;
  assign o_dmem_we  = dmem_we_q;
  assign o_alu_src  = alu_src_q;
  assign o_signext  = signext_q;
  assign o_rf_we    = rf_we_q;
  assign o_wb_sel   = wb_sel_q;
  assign o_trap     = trap_q;
  assign o_state    = state_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the RV32I-subset core.
- Sequences instruction fetch, decode, execute, data-memory access and writeback over the shared single-port datapath: one ALU, register file and immediate decoder.
- Drives every datapath enable and mux select, including the immediate sign-extend control (o_signext).
- Handles instruction- and data-memory req/ack handshakes, with a watchdog that traps on a stuck bus.

Parameters:
- ZEXT_LOGIC_IMM, 0: when 1, o_signext=0 for OP-IMM funct3 100/110/111 (XORI/ORI/ANDI); when 0, o_signext=1 for all instructions.
- MEM_TIMEOUT, 255: maximum cycles to wait for an ack; 0 disables the watchdog.
- TMO_W, 8: watchdog counter width; must hold MEM_TIMEOUT.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_instr  in  32  IR output; stable from DECODE until the next FETCH
- i_imem_ack  in  1  instruction-memory data valid
- i_dmem_ack  in  1  data-memory access complete
- i_br_taken  in  1  branch comparator result, sampled in EXEC
- o_imem_req  out  1  instruction-fetch request
- o_ir_we  out  1  IR load strobe
- o_dmem_req  out  1  data-memory request
- o_dmem_we  out  1  data-memory write (SW)
- o_alu_src  out  1  ALU operand B: 0=rs2, 1=imm
- o_signext  out  1  sign-extend control for the immediate decoder
- o_rf_we  out  1  register-file write strobe
- o_wb_sel  out  2  writeback source: 00 ALU, 01 mem, 10 pc+4, 11 imm
- o_pc_we  out  1  PC write strobe
- o_pc_sel  out  2  next PC: 00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1
- o_instret  out  1  one-cycle pulse per retired instruction
- o_trap  out  1  sticky illegal-opcode/timeout flag
- o_state  out  3  current state, for debug

Behaviour:
- Reset (async, any state): state=FETCH, watchdog=0. All outputs 0 except o_signext=1. No request is held across reset.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: o_imem_req=1 until ack.
  - On the cycle i_imem_ack=1: o_ir_we=1, next=DECODE.
  - i_imem_ack while not requesting: ignored.
- DECODE (always 1 cycle): classify i_instr[6:0] and register o_signext, o_alu_src, o_wb_sel.
  - Legal opcodes: 0000011 LW, 0100011 SW, 1101111 JAL, 1100111 JALR, 1100011 BR, 0110111 LUI, 0010011 OP-IMM, 0110011 OP.
  - Any other opcode: next=TRAP.
  - o_alu_src=1 for every legal opcode except OP and BR.
- EXEC (1 cycle):
  - BR: o_pc_we=1, o_pc_sel=01 if i_br_taken else 00, o_instret=1, next=FETCH.
  - LW/SW: next=MEM.
  - All other legal opcodes: next=WB.
- MEM: o_dmem_req=1 (and o_dmem_we=1 for SW) until i_dmem_ack.
  - On ack: LW -> WB. SW -> o_pc_we=1, o_pc_sel=00, o_instret=1, next=FETCH.
- WB (1 cycle): o_rf_we=1, o_pc_we=1, o_instret=1, next=FETCH. Per-opcode selects:
  - OP/OP-IMM: o_wb_sel=00, o_pc_sel=00.
  - LW: o_wb_sel=01, o_pc_sel=00.
  - JAL: o_wb_sel=10, o_pc_sel=01.
  - JALR: o_wb_sel=10, o_pc_sel=10.
  - LUI: o_wb_sel=11, o_pc_sel=00.
  - rd=x0 still asserts o_rf_we; the register file discards the write.
- Watchdog:
  - Counts cycles in FETCH/MEM while req=1 and ack=0; clears on ack or state change.
  - When count reaches MEM_TIMEOUT (MEM_TIMEOUT≠0): drop the request, next=TRAP.
  - An ack arriving on the same cycle the limit is hit wins: no trap.
- TRAP: o_trap=1. All strobes and requests 0. Held until reset.
- Strobes (o_ir_we, o_rf_we, o_pc_we, o_instret) are single-cycle and mutually consistent. o_instret coincides with o_pc_we.
- Selects not listed for a state are don't-care but stable (held from DECODE).
- Latency with zero-wait memories (ack on the first req cycle):
  - ALU/LUI/JAL/JALR: 4 cycles.
  - BR: 3 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.

Test Plan:
- ADDI x1,x0,5 (0x00500093), immediate acks -> states 0,1,2,4. WB: o_rf_we=1, o_wb_sel=00, o_alu_src=1, o_signext=1. o_instret on cycle 4.
- LW (0x0000A103), i_dmem_ack delayed 3 cycles -> o_dmem_req high 4 cycles with o_dmem_we=0. WB o_wb_sel=01. Total 8 cycles.
- BEQ, i_br_taken=1 then 0 -> EXEC o_pc_we=1 with o_pc_sel=01 then 00. o_rf_we never asserted.
- Opcode 0x7F -> TRAP after DECODE, o_trap=1, no strobes. Then i_rst pulse mid-cycle -> immediate FETCH with outputs at reset values.
- MEM_TIMEOUT=4, i_imem_ack never asserted -> o_imem_req high 4 cycles, then TRAP. Repeat with ack on the 4th cycle -> no trap.
- ZEXT_LOGIC_IMM=1, ANDI (funct3 111) -> o_signext=0; ADDI -> o_signext=1.
